// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM encodings, ready levels
// and the ALU opcodes the execute stage uses to select DIV / DIVU.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // Decode helpers for the execute stage when it raises start_i / signed_div_i.
  function automatic logic is_div_op(input logic [7:0] aluop);
    return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
  endfunction

  function automatic logic is_signed_div_op(input logic [7:0] aluop);
    return aluop == EXE_DIV_OP;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (one quotient bit per cycle) returning
// {remainder, quotient}. Handshake: requester holds start_i high until it has
// taken result_o while ready_o=1, then drops start_i; annul_i flushes work in flight.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [2*WIDTH:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   op1_abs, op2_abs;
  logic [WIDTH+1:0]   trial;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Magnitudes and sign bookkeeping for the incoming request.
  always_comb begin
    op1_neg = signed_div_i & opdata1_i[WIDTH-1];
    op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    op1_abs = op1_neg ? -opdata1_i : opdata1_i;
    op2_abs = op2_neg ? -opdata2_i : opdata2_i;
  end

  // Trial subtraction on the upper WIDTH+1 bits of the left-shifted dividend;
  // the top bit of trial is the borrow that decides restore vs. keep.
  always_comb begin
    trial    = dividend_q[2*WIDTH:WIDTH-1] - {2'b00, divisor_q};
    quot_fix = neg_quot_q ? -dividend_q[WIDTH-1:0] : dividend_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -dividend_q[2*WIDTH-1:WIDTH] : dividend_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    cnt_d      = cnt_q;
    result_d   = '0;
    ready_d    = DIV_RESULT_NOT_READY;

    case (state_q)
      DIV_FREE: begin
        if (start_i && !annul_i) begin
          dividend_d = {{(WIDTH + 1){1'b0}}, op1_abs};
          divisor_d  = op2_abs;
          neg_quot_d = op1_neg ^ op2_neg;
          neg_rem_d  = op1_neg;
          cnt_d      = '0;
          state_d    = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
        end
      end

      DIV_BY_ZERO: begin
        dividend_d = '0;
        state_d    = annul_i ? DIV_FREE : DIV_END;
      end

      DIV_ON: begin
        if (annul_i) begin
          dividend_d = '0;
          cnt_d      = '0;
          state_d    = DIV_FREE;
        end else begin
          if (trial[WIDTH+1]) begin
            dividend_d = {dividend_q[2*WIDTH-1:0], 1'b0};
          end else begin
            dividend_d = {trial[WIDTH:0], dividend_q[WIDTH-2:0], 1'b1};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_d = DIV_END;
          end
        end
      end

      DIV_END: begin
        // Result is presented (and re-presented) until the requester lets go.
        if (start_i) begin
          result_d = {rem_fix, quot_fix};
          ready_d  = DIV_RESULT_READY;
        end else begin
          state_d = DIV_FREE;
        end
      end

      default: begin
        state_d = DIV_FREE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DIV_FREE;
      dividend_q <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal 8..64, even).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
REQ-005 SHALL have port opdata1_i  input  WIDTH  dividend; sampled with start_i.
REQ-006 SHALL have port opdata2_i  input  WIDTH  divisor; sampled with start_i.
REQ-007 SHALL have port start_i  input  1  request, level held by requester until result consumed.
REQ-008 SHALL have port annul_i  input  1  cancel in-flight operation (pipeline flush).
REQ-009 SHALL have port result_o  output  2*WIDTH  {remainder, quotient}; upper half to HI, lower to LO.
REQ-010 SHALL have port ready_o  output  1  result_o valid.

Function
REQ-011 SHALL implement FSM states IDLE, BY_ZERO, ON, END.
REQ-012 IDLE: start_i=1 and annul_i=0 at edge → BY_ZERO if opdata2_i==0, else ON; operands, mode latched; counter cleared.
REQ-013 IDLE with annul_i=1 SHALL ignore start_i.
REQ-014 ON SHALL perform one restoring shift-subtract step per cycle on absolute values; WIDTH steps, then END.
REQ-015 Step: dividend register 2*WIDTH+1 bits shifted left; subtract divisor from upper WIDTH+1 bits; non-negative → keep difference, quotient bit 1; negative → keep, bit 0.
REQ-016 Signed mode: negative operand replaced by two's-complement negation before ON; quotient negated if operand signs differ; remainder takes dividend sign.
REQ-017 Signed MIN/-1 SHALL yield quotient MIN (wrap), remainder 0; no exception flag.
REQ-018 BY_ZERO SHALL load result 0 and move to END next edge.
REQ-019 END: ready_o=1, result_o held; stays END while start_i=1; start_i=0 → IDLE, ready_o=0, result_o=0 same edge.
REQ-020 annul_i=1 in ON or BY_ZERO SHALL force IDLE next edge, ready_o stays 0, partial result discarded.
REQ-021 annul_i in END SHALL be ignored (result already produced; requester drops start_i).
REQ-022 Latency: start sampled at edge k → ready_o high after edge k+WIDTH+1 (nonzero divisor), k+2 (zero divisor).
REQ-023 result_o and ready_o SHALL be registered; no combinational path from inputs to outputs.
REQ-024 Operand changes while not IDLE SHALL not affect the operation.
REQ-025 Step counter width SHALL be clog2(WIDTH+1); no wrap beyond WIDTH.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, ready_o=0, result_o=0, counter 0, operand registers 0.
REQ-027 Reset mid-operation SHALL abort with no residual state; first post-reset start behaves as fresh.

Structure
REQ-028 State encodings (2 bits), DivFree/DivByZero/DivOn/DivEnd, DivResultReady/NotReady, DIVU/DIV aluop codes SHALL live in the shared defines file.
REQ-029 SHALL be a single module; no sub-module; instantiated beside ex, driven by ex start/operand outputs, annulled by the pipeline flush control.

Verification (WIDTH=32)
REQ-030 Unsigned 100/7 → result_o = {0x00000002, 0x0000000E}, ready_o rises 33 edges after start edge.
REQ-031 Signed -100/7 (0xFFFFFF9C/0x00000007) → {0xFFFFFFFE, 0xFFFFFFF2}; signed 0x80000000/0xFFFFFFFF → {0x00000000, 0x80000000}.
REQ-032 5/0 either mode → result_o=0, ready_o rises 2 edges after start.
REQ-033 annul_i pulse 10 cycles into ON → ready_o never asserts, FSM IDLE; subsequent 9/3 → {0,3} with normal latency.
REQ-034 rst asserted asynchronously mid-ON → outputs 0 immediately; hold start_i in END for 5 cycles → result stable, then drop → ready_o=0 next edge.
